// File: rtl/iq_mapper_pkg.sv
// Shared types and lookup helpers for the IQ symbol mapper.
// Modulation modes, FSM state encoding and bits-per-symbol lookup.
package iq_mapper_pkg;

    typedef enum logic [1:0] {
        MODE_BPSK  = 2'b00,
        MODE_QPSK  = 2'b01,
        MODE_QAM16 = 2'b10,
        MODE_RSVD  = 2'b11
    } mode_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

    function automatic logic [2:0] bitsPerSymbol(input mode_e m);
        case (m)
            MODE_BPSK:  return 3'd1;
            MODE_QAM16: return 3'd4;
            default:    return 3'd2;
        endcase
    endfunction

    // Index of the final symbol within a byte (8/k - 1).
    function automatic logic [2:0] lastSymbolIndex(input mode_e m);
        case (m)
            MODE_BPSK:  return 3'd7;
            MODE_QAM16: return 3'd1;
            default:    return 3'd3;
        endcase
    endfunction

endpackage

// File: rtl/iq_point_lut.sv
// Combinational constellation lookup: the top-aligned symbol bits plus mode
// give the I/Q point. The reserved mode maps like QPSK.
module iq_point_lut
    import iq_mapper_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int AMP    = 30000
) (
    input  logic        [3:0]        sym_i,
    input  mode_e                    mode_i,
    output logic signed [DATA_W-1:0] i_o,
    output logic signed [DATA_W-1:0] q_o
);

    localparam logic signed [DATA_W-1:0] A3 = DATA_W'(AMP);
    localparam logic signed [DATA_W-1:0] A1 = DATA_W'(AMP / 3);

    // Gray-coded 4-level axis: 00 outer+, 01 inner+, 11 inner-, 10 outer-.
    function automatic logic signed [DATA_W-1:0] axisLevel(input logic [1:0] g);
        case (g)
            2'b00:   return A3;
            2'b01:   return A1;
            2'b11:   return -A1;
            default: return -A3;
        endcase
    endfunction

    always_comb begin
        i_o = '0;
        q_o = '0;
        case (mode_i)
            MODE_BPSK: begin
                i_o = sym_i[3] ? -A3 : A3;
            end
            MODE_QAM16: begin
                i_o = axisLevel(sym_i[3:2]);
                q_o = axisLevel(sym_i[1:0]);
            end
            default: begin
                i_o = sym_i[3] ? -A3 : A3;
                q_o = sym_i[2] ? -A3 : A3;
            end
        endcase
    end

endmodule

// File: rtl/iq_symbol_mapper.sv
// Byte-to-IQ symbol mapper with valid/ready handshakes on both sides.
// Optional feature macro: IQ_MAPPER_PHASE_ROT_EN adds a 90-degree-step rotation input.
module iq_symbol_mapper
    import iq_mapper_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int AMP    = 30000
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic        [1:0]        mode,
`ifdef IQ_MAPPER_PHASE_ROT_EN
    input  logic        [1:0]        rot,
`endif
    input  logic        [7:0]        s_data,
    input  logic                     s_valid,
    output logic                     s_ready,
    output logic signed [DATA_W-1:0] m_i,
    output logic signed [DATA_W-1:0] m_q,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic                     m_last
);

    state_e                    state_q;
    mode_e                     mode_q;
    logic        [7:0]         buf_q;
    logic        [2:0]         cnt_q;
    logic signed [DATA_W-1:0]  mi_q;
    logic signed [DATA_W-1:0]  mq_q;
    logic                      valid_q;
    logic                      last_q;

    logic                      advance;
    logic                      accept;
    mode_e                     modeIn;
    mode_e                     symMode_d;
    logic        [7:0]         symBits_d;
    logic        [7:0]         bufNext_d;
    logic signed [DATA_W-1:0]  lutI;
    logic signed [DATA_W-1:0]  lutQ;
    logic signed [DATA_W-1:0]  pointI_d;
    logic signed [DATA_W-1:0]  pointQ_d;

    assign advance = valid_q && m_ready;
    assign s_ready = (state_q == ST_IDLE) || (advance && last_q);
    assign accept  = s_valid && s_ready;
    assign modeIn  = mode_e'(mode);

    // A freshly accepted byte is mapped straight from s_data so that a byte
    // taken on the last-symbol edge follows without a bubble.
    assign symMode_d = accept ? modeIn : mode_q;
    assign symBits_d = accept ? s_data : buf_q;
    assign bufNext_d = symBits_d << bitsPerSymbol(symMode_d);

    iq_point_lut #(
        .DATA_W (DATA_W),
        .AMP    (AMP)
    ) u_lut (
        .sym_i  (symBits_d[7:4]),
        .mode_i (symMode_d),
        .i_o    (lutI),
        .q_o    (lutQ)
    );

`ifdef IQ_MAPPER_PHASE_ROT_EN
    logic [1:0] rot_q;
    logic [1:0] rotSel_d;

    assign rotSel_d = accept ? rot : rot_q;

    always_comb begin
        pointI_d = lutI;
        pointQ_d = lutQ;
        case (rotSel_d)
            2'd1: begin
                pointI_d = -lutQ;
                pointQ_d = lutI;
            end
            2'd2: begin
                pointI_d = -lutI;
                pointQ_d = -lutQ;
            end
            2'd3: begin
                pointI_d = lutQ;
                pointQ_d = -lutI;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rot_q <= 2'd0;
        end else if (accept) begin
            rot_q <= rot;
        end
    end
`else
    assign pointI_d = lutI;
    assign pointQ_d = lutQ;
`endif

    // cnt_q counts symbols still waiting in buf_q behind the one on the output.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            mode_q  <= MODE_BPSK;
            buf_q   <= '0;
            cnt_q   <= '0;
            mi_q    <= '0;
            mq_q    <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else if (accept) begin
            state_q <= ST_SHIFT;
            mode_q  <= modeIn;
            buf_q   <= bufNext_d;
            cnt_q   <= lastSymbolIndex(modeIn);
            mi_q    <= pointI_d;
            mq_q    <= pointQ_d;
            valid_q <= 1'b1;
            last_q  <= 1'b0;
        end else if (advance) begin
            if (last_q) begin
                state_q <= ST_IDLE;
                buf_q   <= '0;
                cnt_q   <= '0;
                valid_q <= 1'b0;
                last_q  <= 1'b0;
            end else begin
                buf_q   <= bufNext_d;
                cnt_q   <= cnt_q - 3'd1;
                mi_q    <= pointI_d;
                mq_q    <= pointQ_d;
                last_q  <= (cnt_q == 3'd1);
            end
        end
    end

    assign m_i     = mi_q;
    assign m_q     = mq_q;
    assign m_valid = valid_q;
    assign m_last  = last_q;

endmodule

// File: tb/tb_iq_symbol_mapper.sv
// Self-checking bench for iq_symbol_mapper: directed scenarios plus random
// traffic scored against a queue-based symbol model.
module tb_iq_symbol_mapper;

    localparam int DATA_W = 16;
    localparam int AMP    = 30000;
    localparam int A1     = AMP / 3;

    typedef struct {
        int i;
        int q;
        bit last;
    } sym_t;

    logic                     clk;
    logic                     reset_n;
    logic        [1:0]        mode;
    logic        [7:0]        s_data;
    logic                     s_valid;
    logic                     s_ready;
    logic signed [DATA_W-1:0] m_i;
    logic signed [DATA_W-1:0] m_q;
    logic                     m_valid;
    logic                     m_ready;
    logic                     m_last;
    logic        [1:0]        rotVal;

    sym_t expQ[$];
    int   testsRun    = 0;
    int   testsFailed = 0;
    bit   lastAccepted;

    iq_symbol_mapper #(
        .DATA_W (DATA_W),
        .AMP    (AMP)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .mode    (mode),
`ifdef IQ_MAPPER_PHASE_ROT_EN
        .rot     (rotVal),
`endif
        .s_data  (s_data),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .m_i     (m_i),
        .m_q     (m_q),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_last  (m_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int axisLevel(input int g);
        case (g)
            0:       return AMP;
            1:       return A1;
            3:       return -A1;
            default: return -AMP;
        endcase
    endfunction

    // Expand one accepted byte into its expected symbol list.
    task automatic pushByte(input logic [7:0] d, input logic [1:0] md, input logic [1:0] r);
        int k, n, bits, iv, qv, tmp;
        k = (md == 2'd0) ? 1 : ((md == 2'd2) ? 4 : 2);
        n = 8 / k;
        for (int idx = 0; idx < n; idx++) begin
            bits = (int'(d) >> (8 - k * (idx + 1))) & ((1 << k) - 1);
            if (k == 1) begin
                iv = (bits != 0) ? -AMP : AMP;
                qv = 0;
            end else if (k == 2) begin
                iv = ((bits >> 1) != 0) ? -AMP : AMP;
                qv = ((bits & 1) != 0) ? -AMP : AMP;
            end else begin
                iv = axisLevel(bits >> 2);
                qv = axisLevel(bits & 3);
            end
            if (r == 2'd1) begin
                tmp = iv; iv = -qv; qv = tmp;
            end else if (r == 2'd2) begin
                iv = -iv; qv = -qv;
            end else if (r == 2'd3) begin
                tmp = iv; iv = qv; qv = -tmp;
            end
            expQ.push_back('{i: iv, q: qv, last: (idx == n - 1)});
        end
    endtask

    task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        testsRun++;
        assert (got === exp)
        else begin
            testsFailed++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic sv, input logic [7:0] sd, input logic [1:0] md, input logic mr);
        s_valid = sv;
        s_data  = sd;
        mode    = md;
        m_ready = mr;
    endtask

    // Called at a falling edge with inputs applied; checks, then advances one cycle.
    task automatic checkOutput();
        bit expReady, xfer, acc;
        #1;
        expReady = (expQ.size() == 0) || (m_ready && expQ.size() == 1);
        check("s_ready", s_ready, expReady);
        check("m_valid", m_valid, expQ.size() > 0);
        if (expQ.size() > 0) begin
            check("m_i", m_i, expQ[0].i);
            check("m_q", m_q, expQ[0].q);
            check("m_last", m_last, expQ[0].last);
        end
        xfer = (expQ.size() > 0) && m_ready;
        acc  = s_valid && expReady;
        @(posedge clk);
        if (xfer) void'(expQ.pop_front());
        if (acc) pushByte(s_data, mode, rotVal);
        lastAccepted = acc;
        @(negedge clk);
    endtask

    task automatic step(input logic sv, input logic [7:0] sd, input logic [1:0] md, input logic mr);
        applyStimulus(sv, sd, md, mr);
        checkOutput();
    endtask

    task automatic sendByte(input logic [7:0] d, input logic [1:0] md, input logic mr);
        lastAccepted = 1'b0;
        for (int t = 0; t < 40 && !lastAccepted; t++) step(1'b1, d, md, mr);
        check("byte_accepted", lastAccepted, 1);
    endtask

    task automatic drain(input logic [1:0] md);
        for (int t = 0; t < 40 && expQ.size() > 0; t++) step(1'b0, 8'h00, md, 1'b1);
        check("drained_idle", m_valid, 0);
    endtask

    task automatic doReset();
        reset_n = 1'b0;
        s_valid = 1'b0;
        #1;
        check("rst_m_i", m_i, 0);
        check("rst_m_q", m_q, 0);
        check("rst_m_valid", m_valid, 0);
        check("rst_m_last", m_last, 0);
        expQ.delete();
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0;
        rotVal  = 2'd0;
        applyStimulus(1'b0, 8'h00, 2'd0, 1'b1);
        @(negedge clk);
        doReset();
        step(1'b0, 8'h00, 2'd0, 1'b1);

        // QPSK Gray walk through all four quadrants.
        sendByte(8'h1E, 2'd1, 1'b1);
        drain(2'd1);

        // 16-QAM mixing inner and outer levels.
        sendByte(8'h1D, 2'd2, 1'b1);
        drain(2'd2);

        // Back-to-back BPSK bytes, second taken on the final transfer edge.
        sendByte(8'hA5, 2'd0, 1'b1);
        sendByte(8'h3C, 2'd0, 1'b1);
        drain(2'd0);

        // Downstream stall after the first QPSK symbol.
        sendByte(8'h1E, 2'd1, 1'b1);
        for (int t = 0; t < 3; t++) step(1'b0, 8'h00, 2'd1, 1'b0);
        drain(2'd1);

        // Mode switched mid-byte must not affect the byte in flight.
        sendByte(8'hB4, 2'd2, 1'b1);
        step(1'b0, 8'h00, 2'd0, 1'b1);
        drain(2'd0);

        // Reserved mode behaves like QPSK.
        sendByte(8'h6C, 2'd3, 1'b1);
        drain(2'd3);

        // Reset in the middle of a stalled byte.
        sendByte(8'h5A, 2'd1, 1'b0);
        step(1'b0, 8'h00, 2'd1, 1'b0);
        doReset();
        step(1'b0, 8'h00, 2'd1, 1'b1);

`ifdef IQ_MAPPER_PHASE_ROT_EN
        rotVal = 2'd1;
        sendByte(8'h00, 2'd1, 1'b1);
        rotVal = 2'd0;
        drain(2'd1);
`endif

        for (int n = 0; n < 400; n++) begin
`ifdef IQ_MAPPER_PHASE_ROT_EN
            rotVal = 2'($urandom_range(0, 3));
`endif
            step(($urandom_range(0, 9) < 7), 8'($urandom), 2'($urandom_range(0, 3)),
                 ($urandom_range(0, 3) != 0));
        end
        drain(2'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
